riscv_wb: RTL and testbench
===========================

RISCV_WB -- requirements
Module: riscv_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered writeback entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_wb_rdy  input  1  upstream entry valid.
REQ-006 SHALL have port mem_wb_ack  output  1  entry accepted this cycle.
REQ-007 SHALL have port mem_wb_data  input  XLEN  result value.
REQ-008 SHALL have port mem_wb_rd  input  5  destination register index.
REQ-009 SHALL have port mem_wb_wen  input  1  entry writes a register.
REQ-010 SHALL have port wb_rf_we  output  1  register-file write strobe.
REQ-011 SHALL have port wb_rf_waddr  output  5  write address.
REQ-012 SHALL have port wb_rf_wdata  output  XLEN  write data.
REQ-013 SHALL have port wb_rf_rdy  input  1  register file accepts the write this cycle.
REQ-014 SHALL have port wb_fwd_vld  output  1  head entry holds a pending nonzero-rd write.
REQ-015 SHALL have port wb_fwd_rd  output  5  head rd; wb_fwd_data output XLEN head data (forwarding to ID/EX).
REQ-016 SHALL have port wb_retired  output  32  count of retired entries.

Function
REQ-017 Transfer SHALL occur on a cycle where mem_wb_rdy and mem_wb_ack are both high; no other cycle SHALL change buffer contents on the input side.
REQ-018 mem_wb_ack SHALL equal (occupancy < DEPTH), a function of registered state only; no combinational path from mem_wb_rdy or wb_rf_rdy.
REQ-019 Accepted entries SHALL be stored in a FIFO of DEPTH entries {data, rd, wen}; minimum latency from transfer to wb_rf_we SHALL be 1 cycle.
REQ-020 Head "needs write" SHALL be wen==1 and rd!=0.
REQ-021 wb_rf_we SHALL equal head valid AND needs write; wb_rf_waddr/wb_rf_wdata SHALL equal head rd/data whenever head valid, else zero.
REQ-022 Head SHALL pop when valid AND (not needs write OR wb_rf_rdy); a non-writing entry (wen=0 or rd=0) SHALL pop in one cycle without asserting wb_rf_we.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-024 When full, mem_wb_ack SHALL be low even if the head pops that cycle; ack rises the following cycle.
REQ-025 When empty, wb_rf_we and wb_fwd_vld SHALL be low regardless of inputs.
REQ-026 Read/write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and low bits equal, empty = pointers equal.
REQ-027 wb_fwd_vld SHALL equal wb_rf_we; wb_fwd_rd/wb_fwd_data SHALL mirror wb_rf_waddr/wb_rf_wdata.
REQ-028 wb_retired SHALL increment by 1 on every pop, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-029 rst high at a rising edge SHALL empty the FIFO, zero both pointers and wb_retired, regardless of in-flight handshakes.
REQ-030 During and the cycle after reset: mem_wb_ack=1, wb_rf_we=0, wb_fwd_vld=0, wb_rf_waddr=0, wb_rf_wdata=0; a transfer coinciding with rst high SHALL be discarded.

Structure
REQ-031 XLEN default, register index width (5), and the writeback entry struct {data, rd, wen} SHALL live in the shared riscv package.
REQ-032 The buffer SHALL be a separate sub-module riscv_wb_fifo (parameterised DEPTH, width); riscv_wb holds pop/write/counter logic.

Verification
REQ-033 Single entry: rdy=1, data=0x12345678, rd=5, wen=1, rf_rdy=1 -> next cycle we=1, waddr=5, wdata=0x12345678, fwd_vld=1; following cycle empty, retired=1.
REQ-034 Backpressure: rf_rdy=0, push 3 writing entries at DEPTH=2 -> ack low after 2nd transfer, 3rd held; rf_rdy=1 -> writes in order, ack high one cycle after first pop.
REQ-035 x0/no-write: push rd=0 wen=1 then rd=7 wen=0, rf_rdy=0 -> both pop one per cycle, we never asserted, retired=2.
REQ-036 Streaming: rdy=1 and rf_rdy=1 for 10 cycles, data incrementing -> 10 writes, one per cycle, occupancy never exceeds 1, retired=10.
REQ-037 Reset mid-operation: FIFO full, rf_rdy=0, assert rst 1 cycle -> next cycle ack=1, we=0, retired=0; previously buffered entries never written.
REQ-038 Counter wrap: force retired=0xFFFFFFFF via 2^32-equivalent preload hook or long run -> one pop yields 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, register index width and the
// writeback entry carried from MEM/WB into the writeback buffer.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [REG_W-1:0] rd;
        logic             wen;
    } wb_entry_t;

    // x0 is hardwired to zero, so a write to it is dropped like wen=0.
    function automatic logic needs_write(input wb_entry_t e);
        return e.wen && (e.rd != '0);
    endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// Power-of-two FIFO with wrap-bit pointers; the owner only pushes when not
// full and only pops when not empty.
module riscv_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
    end

    // The extra MSB distinguishes full from empty when the index bits match.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/riscv_wb.sv
// Writeback stage: buffers MEM/WB results, drains them into the register file
// and exposes the head entry for forwarding. XLEN must match riscv_pkg::XLEN.
module riscv_wb
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_wb_rdy,
    output logic                 mem_wb_ack,
    input  logic [XLEN-1:0]      mem_wb_data,
    input  logic [REG_W-1:0]     mem_wb_rd,
    input  logic                 mem_wb_wen,
    output logic                 wb_rf_we,
    output logic [REG_W-1:0]     wb_rf_waddr,
    output logic [XLEN-1:0]      wb_rf_wdata,
    input  logic                 wb_rf_rdy,
    output logic                 wb_fwd_vld,
    output logic [REG_W-1:0]     wb_fwd_rd,
    output logic [XLEN-1:0]      wb_fwd_data,
    output logic [31:0]          wb_retired,
    input  logic                 wb_retired_ld,
    input  logic [31:0]          wb_retired_ld_val
);

    wb_entry_t   in_entry;
    wb_entry_t   head;
    logic [$bits(wb_entry_t)-1:0] head_raw;
    logic        full, empty;
    logic        head_vld, head_wr;
    logic        push, pop;
    logic [31:0] retired_q, retired_d;

    assign in_entry.data = mem_wb_data;
    assign in_entry.rd   = mem_wb_rd;
    assign in_entry.wen  = mem_wb_wen;

    // Ack depends only on registered occupancy (and reset), never on rdy inputs.
    assign mem_wb_ack = !full || rst;
    assign push       = mem_wb_rdy && mem_wb_ack;

    riscv_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head_raw),
        .full  (full),
        .empty (empty)
    );

    assign head     = wb_entry_t'(head_raw);
    assign head_vld = !empty && !rst;
    assign head_wr  = head_vld && needs_write(head);
    assign pop      = head_vld && (!needs_write(head) || wb_rf_rdy);

    assign wb_rf_we    = head_wr;
    assign wb_rf_waddr = head_vld ? head.rd   : '0;
    assign wb_rf_wdata = head_vld ? head.data : '0;
    assign wb_fwd_vld  = wb_rf_we;
    assign wb_fwd_rd   = wb_rf_waddr;
    assign wb_fwd_data = wb_rf_wdata;
    assign wb_retired  = retired_q;

    // The preload hook lets the wrap of the retire counter be exercised quickly.
    always_comb begin
        retired_d = retired_q + 32'(pop);
        if (wb_retired_ld) begin
            retired_d = wb_retired_ld_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_riscv_wb.sv
// Directed bench for riscv_wb at DEPTH=2 with hand-computed expectations.
module tb_riscv_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wb_rdy;
    logic        mem_wb_ack;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_wen;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        wb_rf_rdy;
    logic        wb_fwd_vld;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic [31:0] wb_retired;
    logic        wb_retired_ld;
    logic [31:0] wb_retired_ld_val;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_wb #(.DEPTH(2), .XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_wb_rdy        (mem_wb_rdy),
        .mem_wb_ack        (mem_wb_ack),
        .mem_wb_data       (mem_wb_data),
        .mem_wb_rd         (mem_wb_rd),
        .mem_wb_wen        (mem_wb_wen),
        .wb_rf_we          (wb_rf_we),
        .wb_rf_waddr       (wb_rf_waddr),
        .wb_rf_wdata       (wb_rf_wdata),
        .wb_rf_rdy         (wb_rf_rdy),
        .wb_fwd_vld        (wb_fwd_vld),
        .wb_fwd_rd         (wb_fwd_rd),
        .wb_fwd_data       (wb_fwd_data),
        .wb_retired        (wb_retired),
        .wb_retired_ld     (wb_retired_ld),
        .wb_retired_ld_val (wb_retired_ld_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] data, input logic [4:0] rd,
                         input logic wen);
        mem_wb_rdy  = rdy;
        mem_wb_data = data;
        mem_wb_rd   = rd;
        mem_wb_wen  = wen;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"},    32'(wb_rf_we),    32'd0);
        check({tag, "_fwd"},   32'(wb_fwd_vld),  32'd0);
        check({tag, "_waddr"}, 32'(wb_rf_waddr), 32'd0);
        check({tag, "_wdata"}, wb_rf_wdata,      32'd0);
    endtask

    initial begin
        rst = 1'b1;
        wb_rf_rdy = 1'b1;
        wb_retired_ld = 1'b0;
        wb_retired_ld_val = '0;
        drive(1'b1, 32'hDEAD_BEEF, 5'd9, 1'b1);
        tick();
        tick();
        check("rst_ack", 32'(mem_wb_ack), 32'd1);
        check_idle("rst");
        check("rst_retired", wb_retired, 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check_idle("post_rst");
        check("post_rst_ack", 32'(mem_wb_ack), 32'd1);

        // Single entry
        drive(1'b1, 32'h1234_5678, 5'd5, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("single_we",    32'(wb_rf_we),    32'd1);
        check("single_waddr", 32'(wb_rf_waddr), 32'd5);
        check("single_wdata", wb_rf_wdata,      32'h1234_5678);
        check("single_fvld",  32'(wb_fwd_vld),  32'd1);
        check("single_frd",   32'(wb_fwd_rd),   32'd5);
        check("single_fdata", wb_fwd_data,      32'h1234_5678);
        tick();
        check("single_empty_we", 32'(wb_rf_we), 32'd0);
        check("single_retired",  wb_retired,    32'd1);

        // Backpressure with three writing entries
        wb_rf_rdy = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 1'b1);
        check("bp_ack0", 32'(mem_wb_ack), 32'd1);
        tick();
        drive(1'b1, 32'hB, 5'd2, 1'b1);
        check("bp_ack1", 32'(mem_wb_ack), 32'd1);
        tick();
        drive(1'b1, 32'hC, 5'd3, 1'b1);
        check("bp_full_ack", 32'(mem_wb_ack),  32'd0);
        check("bp_head_a",   32'(wb_rf_waddr), 32'd1);
        check("bp_we_held",  32'(wb_rf_we),    32'd1);
        tick();
        check("bp_still_full", 32'(mem_wb_ack), 32'd0);
        wb_rf_rdy = 1'b1;
        #1;
        check("bp_full_pop_ack", 32'(mem_wb_ack), 32'd0);
        check("bp_wdata_a",      wb_rf_wdata,     32'hA);
        tick();
        check("bp_ack_rise", 32'(mem_wb_ack),  32'd1);
        check("bp_head_b",   32'(wb_rf_waddr), 32'd2);
        check("bp_wdata_b",  wb_rf_wdata,      32'hB);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("bp_head_c",  32'(wb_rf_waddr), 32'd3);
        check("bp_wdata_c", wb_rf_wdata,      32'hC);
        tick();
        check("bp_drained_we", 32'(wb_rf_we), 32'd0);
        check("bp_retired",    wb_retired,    32'd4);

        // x0 and wen=0 entries drain without a write strobe
        wb_rf_rdy = 1'b0;
        drive(1'b1, 32'h5555_0000, 5'd0, 1'b1);
        tick();
        drive(1'b1, 32'h7777_0000, 5'd7, 1'b0);
        check("x0_we",    32'(wb_rf_we),   32'd0);
        check("x0_fwd",   32'(wb_fwd_vld), 32'd0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("nowen_we",    32'(wb_rf_we),    32'd0);
        check("nowen_waddr", 32'(wb_rf_waddr), 32'd7);
        tick();
        check("nowr_we",      32'(wb_rf_we), 32'd0);
        check("nowr_retired", wb_retired,    32'd6);

        // Streaming: one write per cycle, buffer never fills
        wb_rf_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 5'(i + 1), 1'b1);
            check("stream_ack", 32'(mem_wb_ack), 32'd1);
            tick();
            check("stream_we",    32'(wb_rf_we),    32'd1);
            check("stream_wdata", wb_rf_wdata,      32'h100 + 32'(i));
            check("stream_waddr", 32'(wb_rf_waddr), 32'(i + 1));
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check("stream_done_we", 32'(wb_rf_we), 32'd0);
        check("stream_retired", wb_retired,    32'd16);

        // Reset while full and stalled
        wb_rf_rdy = 1'b0;
        drive(1'b1, 32'hE1, 5'd11, 1'b1);
        tick();
        drive(1'b1, 32'hE2, 5'd12, 1'b1);
        tick();
        check("mid_full_ack", 32'(mem_wb_ack), 32'd0);
        rst = 1'b1;
        drive(1'b1, 32'hE3, 5'd13, 1'b1);
        #1;
        check("mid_rst_ack", 32'(mem_wb_ack), 32'd1);
        check_idle("mid_rst");
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        #1;
        check("mid_after_ack", 32'(mem_wb_ack), 32'd1);
        check_idle("mid_after");
        check("mid_retired", wb_retired, 32'd0);
        wb_rf_rdy = 1'b1;
        tick();
        check("mid_never_we", 32'(wb_rf_we), 32'd0);
        check("mid_retired2", wb_retired,    32'd0);

        // Retire counter wrap
        wb_retired_ld = 1'b1;
        wb_retired_ld_val = 32'hFFFF_FFFF;
        tick();
        wb_retired_ld = 1'b0;
        check("wrap_preload", wb_retired, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0, 5'd4, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check("wrap_zero", wb_retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
